// File: rtl/fifo_param_pkg.sv
// Shared types for the parametrised FIFO controller: operation-state codes and op-select values.
// Optional sticky error flags are enabled with the FIFO_STICKY_ERR_EN macro.
package fifo_param_pkg;

   typedef enum logic [2:0] {
      ST_INIT     = 3'b000,
      ST_WRITE    = 3'b001,
      ST_READ     = 3'b010,
      ST_WR_ERROR = 3'b011,
      ST_RD_ERROR = 3'b100,
      ST_WR_RD    = 3'b101
   } state_t;

   // Request pair {rd_en, wr_en} viewed as a single selector.
   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_WR   = 2'b01,
      OP_RD   = 2'b10,
      OP_WRRD = 2'b11
   } op_t;

   // Codes 110/111 can never be stored, but map them to INIT should they ever appear.
   function automatic state_t code_to_state(input logic [2:0] code);
      if (code > 3'b101) return ST_INIT;
      return state_t'(code);
   endfunction

endpackage

// File: rtl/fifo_op_decode.sv
// Combinational per-edge decode of the request pair against full/empty flags.
// Produces the next operation state, the storage enables and the next ack/err pulse values.
module fifo_op_decode
   import fifo_param_pkg::*;
(
   input  logic   wr_en,
   input  logic   rd_en,
   input  logic   full,
   input  logic   empty,
   output state_t next_state,
   output logic   do_wr,
   output logic   do_rd,
   output logic   wr_ack,
   output logic   wr_err,
   output logic   rd_ack,
   output logic   rd_err
);

   op_t op;
   assign op = op_t'({rd_en, wr_en});

   always_comb begin
      // NOTE: every output gets a default before the case so no path can infer a latch.
      next_state = ST_INIT;
      do_wr      = 1'b0;
      do_rd      = 1'b0;
      wr_ack     = 1'b0;
      wr_err     = 1'b0;
      rd_ack     = 1'b0;
      rd_err     = 1'b0;
      case (op)
         OP_WR: begin
            if (full) begin
               next_state = ST_WR_ERROR;
               wr_err     = 1'b1;
            end else begin
               next_state = ST_WRITE;
               do_wr      = 1'b1;
               wr_ack     = 1'b1;
            end
         end
         OP_RD: begin
            if (empty) begin
               next_state = ST_RD_ERROR;
               rd_err     = 1'b1;
            end else begin
               next_state = ST_READ;
               do_rd      = 1'b1;
               rd_ack     = 1'b1;
            end
         end
         OP_WRRD: begin
            // DEPTH >= 2, so full and empty are never both true.
            if (empty) begin
               next_state = ST_RD_ERROR;
               do_wr      = 1'b1;
               wr_ack     = 1'b1;
               rd_err     = 1'b1;
            end else if (full) begin
               next_state = ST_WR_ERROR;
               do_rd      = 1'b1;
               rd_ack     = 1'b1;
               wr_err     = 1'b1;
            end else begin
               next_state = ST_WR_RD;
               do_wr      = 1'b1;
               do_rd      = 1'b1;
               wr_ack     = 1'b1;
               rd_ack     = 1'b1;
            end
         end
         default: next_state = ST_INIT;
      endcase
   end

endmodule

// File: rtl/fifo_param_ctrl.sv
// Parametrised synchronous FIFO: storage, pointers, occupancy counter and registered status pulses.
// Define FIFO_STICKY_ERR_EN to build the sticky overflow/underflow flags; otherwise err_sticky is 0.
module fifo_param_ctrl
   import fifo_param_pkg::*;
#(
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 8,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [DATA_W-1:0] din,
   input  logic              err_clr,
   output logic [DATA_W-1:0] dout,
   output logic [AW:0]       data_count,
   output logic              full,
   output logic              empty,
   output logic [2:0]        state,
   output logic              wr_ack,
   output logic              wr_err,
   output logic              rd_ack,
   output logic              rd_err,
   output logic [1:0]        err_sticky
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q,  count_d;
   state_t            state_q,  state_d;
   logic [DATA_W-1:0] dout_q,   dout_d;
   logic              wr_ack_q, wr_ack_d;
   logic              wr_err_q, wr_err_d;
   logic              rd_ack_q, rd_ack_d;
   logic              rd_err_q, rd_err_d;
   logic              do_wr,    do_rd;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);

   fifo_op_decode u_decode (
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .full       (full),
      .empty      (empty),
      .next_state (state_d),
      .do_wr      (do_wr),
      .do_rd      (do_rd),
      .wr_ack     (wr_ack_d),
      .wr_err     (wr_err_d),
      .rd_ack     (rd_ack_d),
      .rd_err     (rd_err_d)
   );

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      dout_d   = dout_q;
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         dout_d   = mem_q[rd_ptr_q];
      end
      case ({do_wr, do_rd})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= ST_INIT;
         dout_q   <= '0;
         wr_ack_q <= 1'b0;
         wr_err_q <= 1'b0;
         rd_ack_q <= 1'b0;
         rd_err_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
         dout_q   <= dout_d;
         wr_ack_q <= wr_ack_d;
         wr_err_q <= wr_err_d;
         rd_ack_q <= rd_ack_d;
         rd_err_q <= rd_err_d;
      end
   end

   // NOTE: storage has no reset; the pointers alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (do_wr && !reset) mem_q[wr_ptr_q] <= din;
   end

`ifdef FIFO_STICKY_ERR_EN
   logic [1:0] err_sticky_q, err_sticky_d;

   // A new error at the same edge as err_clr keeps its flag set.
   always_comb begin
      err_sticky_d = err_clr ? 2'b00 : err_sticky_q;
      err_sticky_d = err_sticky_d | {wr_err_d, rd_err_d};
   end

   always_ff @(posedge clk) begin
      if (reset) err_sticky_q <= 2'b00;
      else       err_sticky_q <= err_sticky_d;
   end

   assign err_sticky = err_sticky_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign err_sticky     = 2'b00;
`endif

   assign dout       = dout_q;
   assign data_count = count_q;
   assign state      = code_to_state(state_q);
   assign wr_ack     = wr_ack_q;
   assign wr_err     = wr_err_q;
   assign rd_ack     = rd_ack_q;
   assign rd_err     = rd_err_q;

endmodule

// File: tb/tb_fifo_param_ctrl.sv
// Self-checking bench for fifo_param_ctrl (DATA_W=32, DEPTH=8): directed plan plus random traffic
// compared against a queue-based reference model; honours FIFO_STICKY_ERR_EN.
module tb_fifo_param_ctrl;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 8;
   localparam int AW     = $clog2(DEPTH);

   localparam logic [2:0] S_INIT     = 3'b000;
   localparam logic [2:0] S_WRITE    = 3'b001;
   localparam logic [2:0] S_READ     = 3'b010;
   localparam logic [2:0] S_WR_ERROR = 3'b011;
   localparam logic [2:0] S_RD_ERROR = 3'b100;
   localparam logic [2:0] S_WR_RD    = 3'b101;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              wr_en = 1'b0;
   logic              rd_en = 1'b0;
   logic [DATA_W-1:0] din = '0;
   logic              err_clr = 1'b0;
   logic [DATA_W-1:0] dout;
   logic [AW:0]       data_count;
   logic              full, empty;
   logic [2:0]        state;
   logic              wr_ack, wr_err, rd_ack, rd_err;
   logic [1:0]        err_sticky;

   fifo_param_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .din        (din),
      .err_clr    (err_clr),
      .dout       (dout),
      .data_count (data_count),
      .full       (full),
      .empty      (empty),
      .state      (state),
      .wr_ack     (wr_ack),
      .wr_err     (wr_err),
      .rd_ack     (rd_ack),
      .rd_err     (rd_err),
      .err_sticky (err_sticky)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   // Reference model: FIFO contents as a queue plus the expected registered outputs.
   logic [DATA_W-1:0] model_q [$];
   logic [DATA_W-1:0] exp_dout;
   logic [2:0]        exp_state;
   logic              exp_wr_ack, exp_wr_err, exp_rd_ack, exp_rd_err;
   logic [1:0]        exp_sticky;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ph);
      int n;
      n = model_q.size();
      check({ph, ".state"},  64'(state),      64'(exp_state));
      check({ph, ".count"},  64'(data_count), 64'(n));
      check({ph, ".full"},   64'(full),       64'(n == DEPTH));
      check({ph, ".empty"},  64'(empty),      64'(n == 0));
      check({ph, ".wr_ack"}, 64'(wr_ack),     64'(exp_wr_ack));
      check({ph, ".wr_err"}, 64'(wr_err),     64'(exp_wr_err));
      check({ph, ".rd_ack"}, 64'(rd_ack),     64'(exp_rd_ack));
      check({ph, ".rd_err"}, 64'(rd_err),     64'(exp_rd_err));
      check({ph, ".dout"},   64'(dout),       64'(exp_dout));
      check({ph, ".sticky"}, 64'(err_sticky), 64'(exp_sticky));
   endtask

   task automatic model_edge(input logic w, input logic r, input logic [DATA_W-1:0] d, input logic c);
      int  n;
      logic w_ok, r_ok;
      n    = model_q.size();
      w_ok = w && (n < DEPTH);
      r_ok = r && (n > 0);
      exp_wr_ack = w_ok;
      exp_rd_ack = r_ok;
      exp_wr_err = w && !w_ok;
      exp_rd_err = r && !r_ok;
      if (!w && !r)     exp_state = S_INIT;
      else if (w && !r) exp_state = w_ok ? S_WRITE : S_WR_ERROR;
      else if (!w && r) exp_state = r_ok ? S_READ : S_RD_ERROR;
      else if (w_ok && r_ok) exp_state = S_WR_RD;
      else              exp_state = w_ok ? S_RD_ERROR : S_WR_ERROR;
      if (r_ok) exp_dout = model_q.pop_front();
      if (w_ok) model_q.push_back(d);
`ifdef FIFO_STICKY_ERR_EN
      if (c) exp_sticky = 2'b00;
      exp_sticky = exp_sticky | {exp_wr_err, exp_rd_err};
`else
      exp_sticky = 2'b00;
`endif
   endtask

   // Inputs change on the falling edge; outputs are sampled on the next falling edge.
   task automatic step(input logic w, input logic r, input logic [DATA_W-1:0] d, input logic c,
                       input string ph);
      wr_en = w; rd_en = r; din = d; err_clr = c;
      @(posedge clk);
      model_edge(w, r, d, c);
      @(negedge clk);
      check_all(ph);
   endtask

   task automatic do_reset(input string ph);
      reset = 1'b1; wr_en = 1'b1; rd_en = 1'b1; din = 32'hBAD0_BAD0; err_clr = 1'b0;
      @(posedge clk);
      model_q.delete();
      exp_dout = '0; exp_state = S_INIT; exp_sticky = 2'b00;
      exp_wr_ack = 1'b0; exp_wr_err = 1'b0; exp_rd_ack = 1'b0; exp_rd_err = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      check_all(ph);
   endtask

   initial begin
      do_reset("reset");

      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h100 + i, 1'b0, "fill");
      check("fill.full_flag", 64'(full), 64'd1);

      step(1'b1, 1'b0, 32'hDEAD, 1'b0, "overflow");
      check("overflow.state", 64'(state), 64'(S_WR_ERROR));

      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, 1'b0, "drain");
      check("drain.last_dout", 64'(dout), 64'h107);
      step(1'b0, 1'b1, '0, 1'b0, "underflow");
      check("underflow.dout_hold", 64'(dout), 64'h107);

      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h200 + i, 1'b0, "pre_wrrd");
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 32'h300 + i, 1'b0, "wrrd_wrap");
      check("wrrd_wrap.count", 64'(data_count), 64'd3);

      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, 1'b0, "to_empty");
      step(1'b1, 1'b1, 32'h400, 1'b0, "both_empty");
      check("both_empty.state", 64'(state), 64'(S_RD_ERROR));
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 32'h500 + i, 1'b0, "to_full");
      step(1'b1, 1'b1, 32'h600, 1'b0, "both_full");
      check("both_full.count", 64'(data_count), 64'd7);

      step(1'b0, 1'b1, '0, 1'b0, "to_five");
      step(1'b0, 1'b1, '0, 1'b0, "to_five");
      do_reset("mid_reset");
      check("mid_reset.dout", 64'(dout), 64'd0);
      step(1'b0, 1'b1, '0, 1'b0, "post_reset_rd");
      step(1'b0, 1'b1, '0, 1'b1, "clr_with_err");
      step(1'b0, 1'b0, '0, 1'b1, "clr_only");

      // Random traffic with alternating write/read bias so both full and empty are visited.
      for (int blk = 0; blk < 12; blk++) begin
         int wb;
         wb = blk[0] ? 25 : 75;
         for (int i = 0; i < 30; i++) begin
            logic w, r, c;
            w = ($urandom_range(0, 99) < wb);
            r = ($urandom_range(0, 99) < (100 - wb));
            c = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 149) == 0) do_reset("rand_reset");
            else step(w, r, $urandom, c, "random");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_param_ctrl.md
Name: fifo_param_ctrl

Overview:
- Parametrised synchronous FIFO with an integrated storage array, read/write pointers, occupancy counter and a registered operation-state output.
- Successor to the fixed 8-deep, 3-state-input FIFO control used in the Top design. Generalises width and depth.
- Adds a simultaneous read/write state, full/empty flags and registered acknowledge/error pulses.
- Sits between a producer and a consumer in the same clock domain.

Parameters:
- DATA_W, 32, data word width in bits.
- DEPTH, 8, number of entries. Must be a power of two, ≥2.
- AW, $clog2(DEPTH), pointer width. Derived; not for override.

Ports:
- clk  in  1  single system clock. All logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write request this cycle.
- rd_en  in  1  read request this cycle.
- din  in  DATA_W  write data, sampled at the edge where wr_en=1.
- err_clr  in  1  clears sticky error flags (see Optional Feature).
- dout  out  DATA_W  registered read data.
- data_count  out  AW+1  occupancy, 0..DEPTH.
- full  out  1  data_count==DEPTH (combinational from the count register).
- empty  out  1  data_count==0 (combinational from the count register).
- state  out  3  operation performed at the last edge.
- wr_ack  out  1  write accepted at the last edge.
- wr_err  out  1  write rejected (full) at the last edge.
- rd_ack  out  1  read accepted at the last edge.
- rd_err  out  1  read rejected (empty) at the last edge.
- err_sticky  out  2  bit1 = write overflow seen, bit0 = read underflow seen.

Behaviour:
- Reset (synchronous, when reset=1 at an edge):
  - wr_ptr=0, rd_ptr=0, data_count=0, state=INIT, dout=0.
  - All ack/err outputs = 0, err_sticky=0.
  - Storage contents are not cleared.
  - Reset overrides any wr_en/rd_en in the same cycle. Reset mid-stream discards all data.
- State encoding:
  - INIT=000, WRITE=001, READ=010, WR_ERROR=011, RD_ERROR=100, WR_RD=101.
  - Codes 110 and 111 are unreachable; the decode returns INIT for them.
- Per-edge decode, using the inputs and the current data_count; results are registered:
  - wr_en=0, rd_en=0: state=INIT. No pointer or count change. All pulses 0.
  - wr_en=1, rd_en=0, not full: mem[wr_ptr]<=din, wr_ptr+1, count+1, state=WRITE, wr_ack=1.
  - wr_en=1, rd_en=0, full: no change, state=WR_ERROR, wr_err=1.
  - wr_en=0, rd_en=1, not empty: dout<=mem[rd_ptr], rd_ptr+1, count-1, state=READ, rd_ack=1.
  - wr_en=0, rd_en=1, empty: no change, dout holds, state=RD_ERROR, rd_err=1.
  - Both asserted, 0<count<DEPTH: write and read both performed, count unchanged, state=WR_RD, wr_ack=rd_ack=1.
  - Both asserted, empty: write only, count+1, state=RD_ERROR, wr_ack=1, rd_err=1. No bypass: dout holds.
  - Both asserted, full: read only, count-1, state=WR_ERROR, rd_ack=1, wr_err=1.
- Timing:
  - Read latency is one clock: dout is valid in the cycle after the accepting edge and holds until the next accepted read.
  - Ack/err are single-cycle pulses reflecting only the last edge. Error states persist while the offending request persists.
- Pointers are AW bits and wrap naturally DEPTH-1→0. data_count never exceeds DEPTH and never goes below 0.

Optional Feature:
- Macro: FIFO_STICKY_ERR_EN.
- Defined:
  - err_sticky[1] is set on any wr_err pulse condition; err_sticky[0] is set on any rd_err condition.
  - Both bits are cleared by err_clr=1 at an edge.
  - If an error and err_clr occur in the same cycle, set wins.
  - Reset clears both bits.
- Undefined: err_sticky is tied to 2'b00, err_clr is ignored, and no sticky flops are built.

Decomposition:
- Package fifo_param_pkg holds:
  - the six state constants and the 3-bit state type;
  - op-select constants (NONE/WR/RD/WRRD).
- One combinational sub-module, fifo_op_decode. Inputs: wr_en, rd_en, full, empty. Outputs: next_state, do_wr, do_rd, ack/err next values.
- Top holds the storage, pointers, counter and output registers.

Test Plan (DATA_W=32, DEPTH=8):
- Reset, then 8 writes of 0x100..0x107 → wr_ack each cycle, count 1..8, state=WRITE, full=1 after the 8th.
- 9th write of 0xDEAD while full → wr_err=1, state=WR_ERROR, count stays 8, err_sticky=10 if FIFO_STICKY_ERR_EN.
- 8 reads → dout 0x100..0x107 one cycle after each read, count 8..0, empty=1. A 9th read → rd_err=1, state=RD_ERROR, dout holds 0x107.
- From count=3, hold wr_en=rd_en=1 for 10 cycles → state=WR_RD, count stays 3, in-order data, pointers wrap past 7 correctly.
- Simultaneous requests at empty → state=RD_ERROR, count=1. Simultaneous requests at full → state=WR_ERROR, count=7, rd_ack=1.
- reset asserted mid-burst at count=5 → next cycle count=0, empty=1, state=INIT, dout=0. A read next → rd_err=1. With the macro defined, err_clr together with a new error → the flag remains set.
